// File: rtl/hazard_controller_pkg.sv
// Shared RV32I opcode constants used by the hazard controller and its class decoder.
package hazard_controller_pkg;

   localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;

endpackage

// File: rtl/hazard_controller_opcode_class_decode.sv
// Opcode class decode: which register fields an instruction reads or writes.
// Unknown opcodes belong to no class.
module opcode_class_decode
   import hazard_controller_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic       writes_rd_o,
   output logic       uses_rs1_o,
   output logic       uses_rs2_o
);

   always_comb begin
      writes_rd_o = 1'b0;
      uses_rs1_o  = 1'b0;
      uses_rs2_o  = 1'b0;
      case (opcode_i)
         OPC_ARI_RTYPE: begin
            writes_rd_o = 1'b1;
            uses_rs1_o  = 1'b1;
            uses_rs2_o  = 1'b1;
         end
         OPC_ARI_ITYPE, OPC_LOAD, OPC_JALR: begin
            writes_rd_o = 1'b1;
            uses_rs1_o  = 1'b1;
         end
         OPC_STORE, OPC_BRANCH: begin
            uses_rs1_o  = 1'b1;
            uses_rs2_o  = 1'b1;
         end
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            writes_rd_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_controller.sv
// Forwarding, load-use stall and branch-flush control for the three-stage pipeline,
// with registered stall/flush event counters.
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [6:0]       OpcodeX,
   input  logic [6:0]       OpcodeW,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic             isZero,
   output logic             CWE2,
   output logic             noop,
   output logic             ForwardA,
   output logic             ForwardB,
   output logic             PCDelay,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   logic w_writes_rd, w_uses_rs1, w_uses_rs2;
   logic x_writes_rd, x_uses_rs1, x_uses_rs2;
   logic match_a, match_b, load_use, taken;
   logic unused_class;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   opcode_class_decode u_dec_w (
      .opcode_i    (OpcodeW),
      .writes_rd_o (w_writes_rd),
      .uses_rs1_o  (w_uses_rs1),
      .uses_rs2_o  (w_uses_rs2)
   );

   opcode_class_decode u_dec_x (
      .opcode_i    (OpcodeX),
      .writes_rd_o (x_writes_rd),
      .uses_rs1_o  (x_uses_rs1),
      .uses_rs2_o  (x_uses_rs2)
   );

   // Only the producer's write class and the consumer's read classes matter here.
   assign unused_class = ^{w_uses_rs1, w_uses_rs2, x_writes_rd};

   assign match_a  = w_writes_rd & x_uses_rs1 & (rs1 == rd);
   assign match_b  = w_writes_rd & x_uses_rs2 & (rs2 == rd);
   assign load_use = (OpcodeW == OPC_LOAD) & (match_a | match_b);
   assign taken    = (OpcodeX == OPC_BRANCH) & ~isZero;

   // A load-use stall overrides everything, including a taken branch.
   always_comb begin
      ForwardA = match_a;
      ForwardB = match_b;
      noop     = taken;
      CWE2     = 1'b1;
      PCDelay  = 1'b0;
      if (load_use) begin
         ForwardA = 1'b0;
         ForwardB = 1'b0;
         noop     = 1'b1;
         CWE2     = 1'b0;
         PCDelay  = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (load_use) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else if (taken) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign StallCount = stall_cnt_q;
   assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed vector bench for hazard_controller: combinational outputs and counter behaviour.
module tb_hazard_controller;
   import hazard_controller_pkg::*;

   localparam int CW = 4;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [6:0]    OpcodeX, OpcodeW;
   logic [4:0]    rd, rs1, rs2;
   logic          isZero;
   logic          CWE2, noop, ForwardA, ForwardB, PCDelay;
   logic [CW-1:0] StallCount, FlushCount;

   int tests  = 0;
   int failed = 0;
   logic [CW-1:0] exp_stall, exp_flush;

   hazard_controller #(.CNT_W(CW)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .OpcodeX    (OpcodeX),
      .OpcodeW    (OpcodeW),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .isZero     (isZero),
      .CWE2       (CWE2),
      .noop       (noop),
      .ForwardA   (ForwardA),
      .ForwardB   (ForwardB),
      .PCDelay    (PCDelay),
      .StallCount (StallCount),
      .FlushCount (FlushCount)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      string      name;
      logic [6:0] opw;
      logic [6:0] opx;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       iz;
      logic [4:0] exp_out;   // {ForwardA, ForwardB, noop, CWE2, PCDelay}
      logic       stall_inc;
      logic       flush_inc;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic apply(input logic [6:0] opw, input logic [6:0] opx, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic iz);
      OpcodeW = opw; OpcodeX = opx; rd = d; rs1 = s1; rs2 = s2; isZero = iz;
   endtask

   function automatic logic [4:0] outs();
      return {ForwardA, ForwardB, noop, CWE2, PCDelay};
   endfunction

   initial begin
      //              name          W              X              rd  rs1 rs2 iz  FA FB noop CWE2 PCD   st fl
      vecs[0]  = '{"r_to_i",      OPC_ARI_RTYPE, OPC_ARI_ITYPE, 5,  5,  6,  1, 5'b10010, 0, 0};
      vecs[1]  = '{"i_to_r_both", OPC_ARI_ITYPE, OPC_ARI_RTYPE, 7,  7,  7,  1, 5'b11010, 0, 0};
      vecs[2]  = '{"br_taken",    OPC_ARI_RTYPE, OPC_BRANCH,    3,  3,  4,  0, 5'b10110, 0, 1};
      vecs[3]  = '{"br_not",      OPC_ARI_RTYPE, OPC_BRANCH,    3,  3,  4,  1, 5'b10010, 0, 0};
      vecs[4]  = '{"ld_use_br",   OPC_LOAD,      OPC_BRANCH,    8,  8,  0,  0, 5'b00101, 1, 0};
      vecs[5]  = '{"ld_nomatch",  OPC_LOAD,      OPC_ARI_RTYPE, 1,  2,  3,  1, 5'b00010, 0, 0};
      vecs[6]  = '{"store_prod",  OPC_STORE,     OPC_ARI_RTYPE, 5,  5,  5,  1, 5'b00010, 0, 0};
      vecs[7]  = '{"ld_use_rs2",  OPC_LOAD,      OPC_STORE,     9,  1,  9,  1, 5'b00101, 1, 0};
      vecs[8]  = '{"jal_jalr",    OPC_JAL,       OPC_JALR,      1,  1,  1,  1, 5'b10010, 0, 0};
      vecs[9]  = '{"lui_lui",     OPC_LUI,       OPC_LUI,       4,  4,  4,  1, 5'b00010, 0, 0};
      vecs[10] = '{"unknown_w",   7'h7F,         OPC_ARI_RTYPE, 2,  2,  2,  1, 5'b00010, 0, 0};
      vecs[11] = '{"auipc_br_b",  OPC_AUIPC,     OPC_BRANCH,    6,  0,  6,  0, 5'b01110, 0, 1};
      vecs[12] = '{"ld_use_x0",   OPC_LOAD,      OPC_ARI_ITYPE, 0,  0,  5,  1, 5'b00101, 1, 0};
      vecs[13] = '{"br_in_w",     OPC_BRANCH,    OPC_ARI_RTYPE, 3,  3,  3,  0, 5'b00010, 0, 0};
      vecs[14] = '{"r_to_load",   OPC_ARI_RTYPE, OPC_LOAD,      10, 10, 10, 1, 5'b10010, 0, 0};

      Reset = 1'b0;
      apply(OPC_ARI_RTYPE, OPC_ARI_RTYPE, 0, 1, 2, 1);
      repeat (2) @(posedge Clock);
      #1;
      check("reset_stall", 32'(StallCount), 32'(0));
      check("reset_flush", 32'(FlushCount), 32'(0));
      exp_stall = '0;
      exp_flush = '0;
      Reset = 1'b1;

      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].opw, vecs[i].opx, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].iz);
         #1;
         check({vecs[i].name, "_outs"}, 32'(outs()), 32'(vecs[i].exp_out));
         @(posedge Clock);
         #1;
         exp_stall = exp_stall + CW'(vecs[i].stall_inc);
         exp_flush = exp_flush + CW'(vecs[i].flush_inc);
         check({vecs[i].name, "_stallcnt"}, 32'(StallCount), 32'(exp_stall));
         check({vecs[i].name, "_flushcnt"}, 32'(FlushCount), 32'(exp_flush));
      end

      // Reset dropped during a load-use stall: counters clear, outputs keep stalling.
      apply(OPC_LOAD, OPC_BRANCH, 8, 8, 0, 0);
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      check("rst_mid_stall_outs", 32'(outs()), 32'(5'b00101));
      check("rst_mid_stall_scnt", 32'(StallCount), 32'(0));
      check("rst_mid_stall_fcnt", 32'(FlushCount), 32'(0));
      Reset = 1'b1;

      // Held load-use for 17 edges: stall counter wraps past 2^CW.
      for (int i = 0; i < 17; i++) @(posedge Clock);
      #1;
      check("stall_wrap", 32'(StallCount), 32'(1));
      check("stall_wrap_flush", 32'(FlushCount), 32'(0));

      // Held taken branch for 15 then 16 edges: flush counter reaches max then wraps.
      apply(OPC_ARI_RTYPE, OPC_BRANCH, 3, 3, 4, 0);
      for (int i = 0; i < 15; i++) @(posedge Clock);
      #1;
      check("flush_max", 32'(FlushCount), 32'(15));
      @(posedge Clock);
      #1;
      check("flush_wrap", 32'(FlushCount), 32'(0));
      check("flush_wrap_stall", 32'(StallCount), 32'(1));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
